mux_rr_stream: RTL and testbench
================================

Name: mux_rr_stream

Overview:
- Parametrised successor to the team's gate-level 2:1 mux.
- Selects one of CH input streams, each WIDTH bits wide, using a valid/ready handshake and round-robin arbitration.
- Drives a registered one-entry output buffer.
- Sits between multiple lab data producers and a single consumer, such as a display/UART path.

Parameters:
- WIDTH, 8, data width per channel in bits (>=1)
- CH, 4, number of input channels (>=2)
- CH_W, $clog2(CH), width of channel index; derived, not to be overridden

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  reset, asynchronous and active-high; the only reset
- in_valid  input  CH  bit i set: channel i presents data
- in_data  input  CH*WIDTH  channel i data at bits [i*WIDTH +: WIDTH]
- in_ready  output  CH  one-hot or zero; bit i set: channel i accepted this cycle
- out_valid  output  1  output buffer holds a word
- out_data  output  WIDTH  buffered word
- out_ch  output  CH_W  channel index the buffered word came from
- out_ready  input  1  consumer accepts out_data this cycle

Behaviour:
- Reset (async assert, sync to clk on release): out_valid=0, out_data=0, out_ch=0, rr pointer ptr=0.
  - in_ready=0 during reset.
- Transfer rules:
  - Input transfer on channel i: in_valid[i] && in_ready[i].
  - Output transfer: out_valid && out_ready.
- load = !out_valid || out_ready. This is the buffer free or draining in the same cycle; full throughput, one word/cycle.
- Arbitration (combinational):
  - When load=1, grant the first channel with in_valid set, searching from ptr upward and wrapping CH-1 -> 0.
  - in_ready = onehot(grant) when load && any in_valid, else 0.
  - in_ready never depends on in_valid of the granted channel being deasserted later in the cycle.
- On a clock edge with a grant to g:
  - out_data<=in_data[g], out_ch<=g, out_valid<=1.
  - ptr<=(g==CH-1)?0:g+1.
- On a clock edge with load=1 and no in_valid: out_valid<=0; ptr, out_data and out_ch hold.
- On a clock edge with load=0 (out_valid && !out_ready):
  - Everything holds.
  - out_data and out_ch stay stable until accepted.
- Latency: one cycle from input transfer to out_valid.
- Two effective states:
  - EMPTY (out_valid=0): any valid input -> FULL.
  - FULL (out_valid=1):
    - out_ready with a pending input -> FULL with new word.
    - out_ready without a pending input -> EMPTY.
    - !out_ready -> FULL hold.
- Fairness: a continuously valid channel is granted at least once every CH output transfers.
- Simultaneous all-valid: grants rotate ptr, ptr+1, … exactly.
- ptr wrap: after a grant to CH-1, ptr=0.
- Reset mid-operation: the buffered word is discarded; no in_ready is issued while rst is high.
- in_data of non-granted channels is ignored. X on those inputs must not propagate.

Optional Feature:
- Macro MUX_FORCE_SEL_EN.
- Defined:
  - Adds ports force_en (input 1) and force_sel (input CH_W).
  - When force_en=1, round-robin is bypassed: grant is force_sel if in_valid[force_sel], else no grant.
  - ptr is not updated on forced grants.
  - force_sel>=CH gives no grant.
- Undefined: ports absent; pure round-robin.

Decomposition:
- Shared package mux_pkg:
  - function for CH_W computation (min 1)
  - localparam default WIDTH/CH
  - typedef for grant one-hot vector per CH
- Natural sub-module rr_arbiter.
  - Inputs: req[CH], ptr, en.
  - Outputs: gnt one-hot, gnt_idx.
  - Reusable by later arbiters.
- The output register stays in mux_rr_stream.

Test Plan:
- Reset with in_valid=4'b1111 → in_ready=0, out_valid=0, out_data=0 while rst=1; after release the first grant is channel 0.
- All four channels valid, data 0x10,0x21,0x32,0x43, out_ready=1 constantly → out_ch sequence 0,1,2,3,0 with matching out_data on consecutive cycles, one word per cycle.
- Only channel 2 valid, out_ready held 0 for 3 cycles after first capture → out_data=0x32, out_ch=2 stable, in_ready=0 during stall; transfer resumes on out_ready=1.
- Channels 1 and 3 valid, ptr=2 → channel 3 granted first, then 1 (wrap), ptr ends at 2.
- Assert rst asynchronously mid-stream with out_valid=1 → out_valid drops immediately without clk edge; ptr=0 after release.
- With MUX_FORCE_SEL_EN: force_en=1, force_sel=1, all valid → only channel 1 granted every cycle, ptr unchanged; force_sel=1 with in_valid[1]=0 → no grant, out_valid=0 next cycle.

Source files
------------

// File: rtl/mux_rr_stream_pkg.sv
// mux_pkg: shared definitions for the round-robin stream mux family.
//   ch_width()  - channel-index width for n channels, never below 1 bit
//   DEFAULT_*   - default data width and channel count
//   gnt_vec_t   - one-hot grant vector for the default channel count
package mux_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CH    = 4;

    function automatic int ch_width(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << w) < n) w = w + 1;
        end
        return w;
    endfunction

    typedef logic [DEFAULT_CH-1:0] gnt_vec_t;

endpackage

// File: rtl/mux_rr_stream_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
// Grants the first requesting channel found searching upward from ptr,
// wrapping CH-1 -> 0. Nothing is granted while en is low.
//   req     [CH]    request per channel
//   ptr     [CH_W]  highest-priority channel this cycle (must be < CH)
//   en              grant enable
//   gnt     [CH]    one-hot grant, or zero
//   gnt_idx [CH_W]  index of the granted channel (0 when no grant)
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int CH   = DEFAULT_CH,
    parameter int CH_W = ch_width(CH)
) (
    input  logic [CH-1:0]   req,
    input  logic [CH_W-1:0] ptr,
    input  logic            en,
    output logic [CH-1:0]   gnt,
    output logic [CH_W-1:0] gnt_idx
);

    always_comb begin
        int              w_idx;
        logic [CH_W-1:0] w_idx_l;
        logic            w_found;
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        w_idx   = 0;
        w_idx_l = '0;
        for (int k = 0; k < CH; k++) begin
            // ptr < CH and k < CH, so one subtraction is enough to wrap
            w_idx = int'(ptr) + k;
            if (w_idx >= CH) w_idx = w_idx - CH;
            w_idx_l = CH_W'(w_idx);
            if (en && !w_found && req[w_idx_l]) begin
                w_found      = 1'b1;
                gnt[w_idx_l] = 1'b1;
                gnt_idx      = w_idx_l;
            end
        end
    end

endmodule

// File: rtl/mux_rr_stream.sv
// mux_rr_stream: CH-channel valid/ready stream mux with round-robin
// arbitration feeding a registered one-entry output buffer.
// Handshake: a word moves on any port in a cycle where valid and ready are
// both high at the rising edge; in_ready is one-hot or zero and never
// depends on anything later in the cycle than in_valid/out_ready.
// The buffer reloads when empty or draining (load), so throughput is one
// word per cycle with one cycle of latency.
//   clk, rst             clock, asynchronous active-high reset
//   in_valid  [CH]       per-channel valid
//   in_data   [CH*WIDTH] channel i at [i*WIDTH +: WIDTH]
//   in_ready  [CH]       per-channel accept
//   out_valid/out_data/out_ch/out_ready  buffered output word and source
// Optional macro MUX_FORCE_SEL_EN adds force_en/force_sel: a forced grant
// takes channel force_sel only, and does not move the round-robin pointer.
module mux_rr_stream
    import mux_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    parameter  int CH    = DEFAULT_CH,
    localparam int CH_W  = ch_width(CH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH-1:0]       in_valid,
    input  logic [CH*WIDTH-1:0] in_data,
    output logic [CH-1:0]       in_ready,
    output logic                out_valid,
    output logic [WIDTH-1:0]    out_data,
    output logic [CH_W-1:0]     out_ch,
`ifdef MUX_FORCE_SEL_EN
    input  logic                force_en,
    input  logic [CH_W-1:0]     force_sel,
`endif
    input  logic                out_ready
);

    logic              r_out_valid;
    logic [WIDTH-1:0]  r_out_data;
    logic [CH_W-1:0]   r_out_ch;
    logic [CH_W-1:0]   r_ptr;

    logic              w_load;
    logic              w_rr_en;
    logic [CH-1:0]     w_rr_gnt;
    logic [CH_W-1:0]   w_rr_idx;
    logic [CH-1:0]     w_gnt;
    logic [CH_W-1:0]   w_idx;
    logic              w_fire;
    logic              w_forced;
    logic [WIDTH-1:0]  w_data;

    assign w_load = !r_out_valid || out_ready;

`ifdef MUX_FORCE_SEL_EN
    logic [CH-1:0] w_sel_gnt;

    assign w_rr_en = w_load && !rst && !force_en;

    always_comb begin
        w_sel_gnt = '0;
        if (w_load && !rst && (32'(force_sel) < CH) && in_valid[force_sel])
            w_sel_gnt[force_sel] = 1'b1;
    end

    assign w_forced = force_en;
    assign w_gnt    = force_en ? w_sel_gnt : w_rr_gnt;
    assign w_idx    = force_en ? force_sel : w_rr_idx;
`else
    assign w_rr_en  = w_load && !rst;
    assign w_forced = 1'b0;
    assign w_gnt    = w_rr_gnt;
    assign w_idx    = w_rr_idx;
`endif

    rr_arbiter #(
        .CH   (CH),
        .CH_W (CH_W)
    ) u_arb (
        .req     (in_valid),
        .ptr     (r_ptr),
        .en      (w_rr_en),
        .gnt     (w_rr_gnt),
        .gnt_idx (w_rr_idx)
    );

    assign w_fire = |w_gnt;

    // AND-OR select on the one-hot grant: unselected channels are masked by
    // zero, so X on their data cannot reach the buffer.
    always_comb begin
        w_data = '0;
        for (int i = 0; i < CH; i++) begin
            w_data = w_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{w_gnt[i]}});
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_ptr       <= '0;
        end else if (w_load) begin
            if (w_fire) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_data;
                r_out_ch    <= w_idx;
                if (!w_forced)
                    r_ptr <= (w_idx == CH_W'(CH-1)) ? '0 : w_idx + 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_gnt;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_mux_rr_stream.sv
// tb_mux_rr_stream: self-checking bench for mux_rr_stream (WIDTH=8, CH=4).
// A behavioural model (pointer + buffer-valid) predicts in_ready every
// cycle and pushes the predicted {ch,data} of each accepted word to exp_q;
// the buffered word is compared against the queue head while out_valid.
module tb_mux_rr_stream;

    localparam int W = 8;
    localparam int N = 4;

    logic           clk;
    logic           rst;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [1:0]     out_ch;
    logic           out_ready;
    logic           force_en;
    logic [1:0]     force_sel;

    mux_rr_stream #(.WIDTH(W), .CH(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
`ifdef MUX_FORCE_SEL_EN
        .force_en  (force_en),
        .force_sel (force_sel),
`endif
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // model state
    logic       m_valid;
    int         m_ptr;
    logic       m_fen;
    int         m_fsel;
    logic [9:0] exp_q[$];

    typedef struct packed {
        logic [3:0] v;
        logic       rdy;
        logic [3:0] er;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_ptr   = 0;
        exp_q.delete();
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic [3:0] v, input logic rdy, output logic [3:0] seen);
        logic       load;
        logic       found;
        int         g;
        int         idx;
        logic [3:0] er;
        logic [9:0] ew;
        in_valid  = v;
        out_ready = rdy;
        #1;
        load  = !m_valid || rdy;
        found = 1'b0;
        g     = 0;
        if (m_fen) begin
            if (m_fsel < N && v[m_fsel]) begin
                found = 1'b1;
                g     = m_fsel;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (!found && v[idx]) begin
                    found = 1'b1;
                    g     = idx;
                end
            end
        end
        if (!load) found = 1'b0;
        er   = found ? 4'(1 << g) : 4'b0000;
        seen = in_ready;
        chk("in_ready", 32'(in_ready), 32'(er));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            if (exp_q.size() == 0) begin
                chk("scoreboard_empty", 32'(exp_q.size()), 32'd1);
            end else begin
                ew = exp_q[0];
                chk("out_word", {22'b0, out_ch, out_data}, {22'b0, ew});
                if (rdy) void'(exp_q.pop_front());
            end
        end
        if (found) exp_q.push_back({2'(g), in_data[g*W +: W]});
        if (load) m_valid = found;
        if (found && !m_fen) m_ptr = (g == N-1) ? 0 : g + 1;
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [3:0] seen;

    initial begin
        tbl[0]  = '{4'b1111, 1'b1, 4'b0001};
        tbl[1]  = '{4'b1111, 1'b1, 4'b0010};
        tbl[2]  = '{4'b1111, 1'b1, 4'b0100};
        tbl[3]  = '{4'b1111, 1'b1, 4'b1000};
        tbl[4]  = '{4'b1111, 1'b1, 4'b0001};
        tbl[5]  = '{4'b0100, 1'b1, 4'b0100};
        tbl[6]  = '{4'b0100, 1'b0, 4'b0000};
        tbl[7]  = '{4'b0100, 1'b0, 4'b0000};
        tbl[8]  = '{4'b0100, 1'b0, 4'b0000};
        tbl[9]  = '{4'b0100, 1'b1, 4'b0100};
        tbl[10] = '{4'b0000, 1'b1, 4'b0000};
        tbl[11] = '{4'b0010, 1'b1, 4'b0010};
        tbl[12] = '{4'b1010, 1'b1, 4'b1000};
        tbl[13] = '{4'b1010, 1'b1, 4'b0010};
        tbl[14] = '{4'b0000, 1'b1, 4'b0000};

        m_fen     = 1'b0;
        m_fsel    = 0;
        force_en  = 1'b0;
        force_sel = 2'd0;
        rst       = 1'b1;
        in_valid  = 4'b1111;
        in_data   = 32'h4332_2110;
        out_ready = 1'b1;
        model_reset();

        // reset holds everything quiet even with all channels requesting
        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_ch", 32'(out_ch), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // rotation, stall hold, wrap from ptr=2
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].v, tbl[i].rdy, seen);
            chk($sformatf("tbl[%0d].in_ready", i), 32'(seen), 32'(tbl[i].er));
        end

        // ptr should have ended at 2
        step(4'b1111, 1'b1, seen);
        chk("ptr_end_2", 32'(seen), 32'b0100);

        // asynchronous reset with a word buffered
        chk("pre_async_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step(4'b1111, 1'b1, seen);
        chk("post_rst_grant0", 32'(seen), 32'b0001);

`ifdef MUX_FORCE_SEL_EN
        m_fen = 1'b1; m_fsel = 1;
        force_en = 1'b1; force_sel = 2'd1;
        for (int i = 0; i < 3; i++) begin
            in_data = $urandom;
            step(4'b1111, 1'b1, seen);
            chk("force_ch1", 32'(seen), 32'b0010);
        end
        step(4'b1101, 1'b1, seen);
        chk("force_no_grant", 32'(seen), 32'b0000);
        m_fen = 1'b0;
        force_en = 1'b0;
        step(4'b1111, 1'b1, seen);
        chk("force_ptr_kept", 32'(seen), 32'b0010);
`endif

        // random traffic, all predicted by the model
        for (int i = 0; i < 400; i++) begin
            in_data = $urandom;
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), seen);
        end

        // drain
        step(4'b0000, 1'b1, seen);
        step(4'b0000, 1'b1, seen);
        chk("drained_queue", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
